// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART blocks: register map, CTRL/STATUS bit positions, TX FSM states.
package apb_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_PEN   = 1;
    localparam int CTRL_PODD  = 2;
    localparam int CTRL_STOP2 = 3;
    localparam int CTRL_IE    = 4;
    localparam int CTRL_W     = 5;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_LVL_LSB = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/apb_uart_tx_sync_fifo.sv
// Generic synchronous FIFO: head data visible combinationally, push/pop commit on the clock edge.
// Pointers carry one extra wrap bit so full/empty/level come straight from their difference.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign level = wr_q - rd_q;
    assign full  = (level == AW'(0) + (AW+1)'(DEPTH));
    assign empty = (wr_q == rd_q);
    assign rdata = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full)
                wr_q <= wr_q + 1'b1;
            if (pop && !empty)
                rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_uart_tx.sv
// APB3 UART transmitter: register file, TX FIFO and a frame serialiser.
// Frame format and divisor are latched when a byte is popped, so reprogramming only affects later frames.
module apb_uart_tx
    import apb_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int RESET_DIV  = 15,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  tx_serial,
    output logic                  tx_done,
    output logic                  irq
);

    localparam int         LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [15:0]          baud_q, baud_d;
    logic                 access, addr_ok, push, pop, bit_end;
    logic [1:0]           reg_sel;
    logic [31:0]          status;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [LW-1:0]        fifo_level;

    tx_state_e            state_q;
    logic [15:0]          cnt_q, div_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_q;
    logic                 par_q, pen_q, stop2_q, stop_q, tx_q, done_q;

    logic                 unused_ok;
    assign unused_ok = ^{PWDATA[31:16], PADDR[1:0]};

    assign access  = PSEL & PENABLE;
    assign addr_ok = (PADDR[ADDR_WIDTH-1:4] == '0);
    assign reg_sel = PADDR[3:2];
    // Fullness is judged before any pop in the same cycle: a full FIFO never accepts.
    assign push    = access & PWRITE & addr_ok & (reg_sel == REG_TXDATA) & !fifo_full;

    assign PREADY    = 1'b1;
    assign tx_serial = tx_q;
    assign tx_done   = done_q;
    assign irq       = ctrl_q[CTRL_IE] & fifo_empty & (state_q == S_IDLE);

    always_comb begin
        PSLVERR = access & (!addr_ok
                  | (PWRITE & (reg_sel == REG_STATUS))
                  | (PWRITE & (reg_sel == REG_TXDATA) & fifo_full));
    end

    always_comb begin
        status                       = '0;
        status[ST_BUSY]              = (state_q != S_IDLE);
        status[ST_FULL]              = fifo_full;
        status[ST_EMPTY]             = fifo_empty;
        status[ST_LVL_LSB +: LW]     = fifo_level;
        PRDATA = '0;
        if (access && !PWRITE && addr_ok) begin
            case (reg_sel)
                REG_STATUS: PRDATA = status;
                REG_CTRL:   PRDATA = 32'(ctrl_q);
                REG_BAUD:   PRDATA = 32'(baud_q);
                default:    PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        baud_d = baud_q;
        if (access && PWRITE && addr_ok) begin
            if (reg_sel == REG_CTRL) ctrl_d = PWDATA[CTRL_W-1:0];
            if (reg_sel == REG_BAUD) baud_d = PWDATA[15:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q <= '0;
            baud_q <= 16'(RESET_DIV);
        end else begin
            ctrl_q <= ctrl_d;
            baud_q <= baud_d;
        end
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .wdata (PWDATA[DATA_BITS-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_end = (cnt_q == div_q);
    // A new frame starts from IDLE, or straight out of the final stop period with no idle gap.
    assign pop = ctrl_q[CTRL_EN] & !fifo_empty &
                 ((state_q == S_IDLE) |
                  ((state_q == S_STOP) & bit_end & (!stop2_q | stop_q)));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                state_q <= S_START;
                tx_q    <= 1'b0;
                cnt_q   <= '0;
                div_q   <= baud_q;
                shift_q <= fifo_rdata;
                bit_q   <= '0;
                par_q   <= (^fifo_rdata) ^ ctrl_q[CTRL_PODD];
                pen_q   <= ctrl_q[CTRL_PEN];
                stop2_q <= ctrl_q[CTRL_STOP2];
                stop_q  <= 1'b0;
                done_q  <= (state_q == S_STOP);
            end else if (state_q == S_IDLE) begin
                tx_q <= 1'b1;
            end else if (!bit_end) begin
                cnt_q <= cnt_q + 16'd1;
            end else begin
                cnt_q <= '0;
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    S_DATA: begin
                        if (bit_q == LAST_BIT) begin
                            state_q <= pen_q ? S_PARITY : S_STOP;
                            tx_q    <= pen_q ? par_q : 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                    S_STOP: begin
                        if (stop2_q && !stop_q) begin
                            stop_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: register vector table plus hand-written frame sequences.
module tb_apb_uart_tx;

    logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, tx_serial, tx_done, irq;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    apb_uart_tx dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_serial(tx_serial),
        .tx_done(tx_done), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (tx_done === 1'b1) done_cnt++;

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, addr, wd, rd, err);
    endtask

    // Waits (bounded) for a start bit, then checks every cycle of the frame and the tx_done pulse.
    task automatic check_frame(input string nm, input logic [7:0] d, input int div,
                               input bit pen, input bit podd, input bit stop2,
                               input int maxw, output int waited);
        logic [15:0] fb;
        int n, len, errs, early;
        waited = 0;
        while (tx_serial !== 1'b0 && waited < maxw) begin
            @(posedge PCLK); #1;
            waited++;
        end
        if (tx_serial !== 1'b0) begin
            chk({nm, "_start"}, 32'(tx_serial), 32'd0);
            return;
        end
        fb = '1;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[1+k] = d[k];
        n = 9;
        if (pen) begin
            fb[n] = (^d) ^ podd;
            n++;
        end
        n = n + 1 + (stop2 ? 1 : 0);
        len = n * (div + 1);
        errs = 0;
        early = 0;
        for (int i = 0; i < len; i++) begin
            if (tx_serial !== fb[i / (div + 1)]) errs++;
            if (i > 0 && tx_done !== 1'b0) early++;
            @(posedge PCLK); #1;
        end
        chk({nm, "_bits"}, 32'(errs), 32'd0);
        chk({nm, "_done"}, 32'({early[7:0], 7'd0, tx_done}), 32'd1);
    endtask

    vec_t        vecs[12];
    logic [31:0] rd;
    logic        err;
    int          w, snap, lows;

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK); #1;

        chk("rst_tx_serial", 32'(tx_serial), 32'd1);
        chk("rst_tx_done",   32'(tx_done),   32'd0);
        chk("rst_irq",       32'(irq),       32'd0);
        chk("rst_prdata",    PRDATA,         32'd0);
        chk("rst_pslverr",   32'(PSLVERR),   32'd0);
        chk("rst_pready",    32'(PREADY),    32'd1);

        vecs[0]  = '{"rd_baud_rst",   1'b0, 8'h0C, 32'h0,         32'h0000_000F, 1'b0};
        vecs[1]  = '{"rd_status_rst", 1'b0, 8'h04, 32'h0,         32'h0000_0004, 1'b0};
        vecs[2]  = '{"rd_ctrl_rst",   1'b0, 8'h08, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{"rd_txdata",     1'b0, 8'h00, 32'h0,         32'h0,         1'b0};
        vecs[4]  = '{"wr_status",     1'b1, 8'h04, 32'h0000_0123, 32'h0,         1'b1};
        vecs[5]  = '{"rd_status_2",   1'b0, 8'h04, 32'h0,         32'h0000_0004, 1'b0};
        vecs[6]  = '{"rd_0x10",       1'b0, 8'h10, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{"wr_0x14",       1'b1, 8'h14, 32'h0000_0055, 32'h0,         1'b1};
        vecs[8]  = '{"wr_ctrl_ie",    1'b1, 8'h08, 32'hFFFF_FFF0, 32'h0,         1'b0};
        vecs[9]  = '{"rd_ctrl_ie",    1'b0, 8'h08, 32'h0,         32'h0000_0010, 1'b0};
        vecs[10] = '{"wr_baud",       1'b1, 8'h0C, 32'hABCD_1234, 32'h0,         1'b0};
        vecs[11] = '{"rd_baud",       1'b0, 8'h0C, 32'h0,         32'h0000_1234, 1'b0};

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
        end
        chk("irq_ie_empty", 32'(irq), 32'd1);

        // Basic 8N1 frame, div=3, with start-bit latency check.
        wr_reg(8'h0C, 32'd3);
        wr_reg(8'h08, 32'h01);
        chk("irq_ie_off", 32'(irq), 32'd0);
        wr_reg(8'h00, 32'hA5);
        check_frame("a5", 8'hA5, 3, 1'b0, 1'b0, 1'b0, 4, w);
        chk("latency", 32'(w), 32'd1);

        // Odd parity, two stop bits.
        wr_reg(8'h08, 32'h0F);
        wr_reg(8'h00, 32'h03);
        check_frame("par_odd", 8'h03, 3, 1'b1, 1'b1, 1'b1, 4, w);

        // Fill with EN=0, overflow, then drain back-to-back.
        wr_reg(8'h08, 32'h00);
        snap = done_cnt;
        for (int i = 0; i < 8; i++) begin
            apb(1'b1, 8'h00, 32'h10 + i, rd, err);
            chk("fill_err", 32'(err), 32'd0);
        end
        apb(1'b1, 8'h00, 32'hEE, rd, err);
        chk("overflow_err", 32'(err), 32'd1);
        apb(1'b0, 8'h04, 32'h0, rd, err);
        chk("status_full", rd, 32'h0000_0802);
        wr_reg(8'h08, 32'h01);
        check_frame("b2b_0", 8'h10, 3, 1'b0, 1'b0, 1'b0, 3, w);
        for (int i = 1; i < 8; i++)
            check_frame("b2b_n", 8'(8'h10 + i), 3, 1'b0, 1'b0, 1'b0, 0, w);
        repeat (4) @(posedge PCLK);
        #1;
        chk("b2b_done_count", 32'(done_cnt - snap), 32'd8);
        apb(1'b0, 8'h04, 32'h0, rd, err);
        chk("status_drained", rd, 32'h0000_0004);

        // Reset in the middle of the data bits with bytes still queued.
        wr_reg(8'h08, 32'h00);
        for (int i = 0; i < 3; i++) wr_reg(8'h00, 32'h30 + i);
        wr_reg(8'h08, 32'h01);
        w = 0;
        while (tx_serial !== 1'b0 && w < 8) begin
            @(posedge PCLK); #1;
            w++;
        end
        chk("rst_mid_started", 32'(tx_serial), 32'd0);
        repeat (8) @(posedge PCLK);
        #1;
        snap = done_cnt;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("rst_mid_line_high", 32'(tx_serial), 32'd1);
        PRESET = 1'b0;
        apb(1'b0, 8'h04, 32'h0, rd, err);
        chk("rst_mid_status", rd, 32'h0000_0004);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge PCLK); #1;
            if (tx_serial !== 1'b1) lows++;
        end
        chk("rst_mid_idle", 32'(lows), 32'd0);
        chk("rst_mid_no_done", 32'(done_cnt - snap), 32'd0);

        // Divisor change mid-frame only applies to the following frame.
        wr_reg(8'h0C, 32'd3);
        wr_reg(8'h00, 32'h5A);
        wr_reg(8'h00, 32'hC3);
        wr_reg(8'h08, 32'h01);
        fork
            begin
                int w1, w2;
                check_frame("div_old", 8'h5A, 3, 1'b0, 1'b0, 1'b0, 3, w1);
                check_frame("div_new", 8'hC3, 7, 1'b0, 1'b0, 1'b0, 0, w2);
            end
            begin
                logic [31:0] r2;
                logic        e2;
                repeat (6) @(posedge PCLK);
                apb(1'b1, 8'h0C, 32'd7, r2, e2);
                chk("div_wr_err", 32'(e2), 32'd0);
                apb(1'b1, 8'h10, 32'd1, r2, e2);
                chk("addr_0x10_err", 32'(e2), 32'd1);
            end
        join
        apb(1'b0, 8'h0C, 32'h0, rd, err);
        chk("baud_readback", rd, 32'h0000_0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
